// File: rtl/extio_bus_arbiter_if.sv
// ExtIO arbiter bus bundle.
// Groups the requester-side handshake (req/addr/we/wdata/be in, gnt/rvalid/rdata/err out)
// and the peripheral-side handshake (p_req/p_addr/p_we/p_wdata/p_be out,
// p_gnt/p_rvalid/p_rdata/p_err in) of extio_bus_arbiter.
//   slave  : the arbiter's view
//   master : the environment's view (requesters plus peripherals)
// Widths must match the parameters of the extio_bus_arbiter instance it connects to.
interface extio_bus_arbiter_if #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64
);
  localparam int unsigned NumPeri = 4;
  localparam int unsigned BeWidth = DataWidth / 8;

  // Requester side
  logic [NumReq-1:0]                req_i;
  logic [NumReq-1:0][AddrWidth-1:0] addr_i;
  logic [NumReq-1:0]                we_i;
  logic [NumReq-1:0][DataWidth-1:0] wdata_i;
  logic [NumReq-1:0][BeWidth-1:0]   be_i;
  logic [NumReq-1:0]                gnt_o;
  logic [NumReq-1:0]                rvalid_o;
  logic [DataWidth-1:0]             rdata_o;
  logic                             err_o;

  // Peripheral side (0 GPIO, 1 Ethernet, 2 SPI, 3 UART)
  logic [NumPeri-1:0]                p_req_o;
  logic [AddrWidth-1:0]              p_addr_o;
  logic                              p_we_o;
  logic [DataWidth-1:0]              p_wdata_o;
  logic [BeWidth-1:0]                p_be_o;
  logic [NumPeri-1:0]                p_gnt_i;
  logic [NumPeri-1:0]                p_rvalid_i;
  logic [NumPeri-1:0][DataWidth-1:0] p_rdata_i;
  logic [NumPeri-1:0]                p_err_i;

  modport slave (
    input  req_i, addr_i, we_i, wdata_i, be_i,
    output gnt_o, rvalid_o, rdata_o, err_o,
    output p_req_o, p_addr_o, p_we_o, p_wdata_o, p_be_o,
    input  p_gnt_i, p_rvalid_i, p_rdata_i, p_err_i
  );

  modport master (
    output req_i, addr_i, we_i, wdata_i, be_i,
    input  gnt_o, rvalid_o, rdata_o, err_o,
    input  p_req_o, p_addr_o, p_we_o, p_wdata_o, p_be_o,
    output p_gnt_i, p_rvalid_i, p_rdata_i, p_err_i
  );
endinterface

// File: rtl/extio_bus_arbiter.sv
// ExtIO register-bus arbiter.
// Shares the ExtIO window between two requesters (core data port, debug module) with
// round-robin arbitration and a single outstanding transaction, and routes each
// transaction to GPIO / Ethernet / SPI / UART by address. Decode misses and peripheral
// timeouts are answered internally with err=1, rdata=0.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : extio_bus_arbiter_if.slave, requester and peripheral handshakes
module extio_bus_arbiter #(
  parameter int unsigned NumReq        = 2,  // fixed at 2 in this revision
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned TimeoutCycles = 1024  // must be >= 2
) (
  input logic                clk_i,
  input logic                rst_ni,
  extio_bus_arbiter_if.slave bus
);

  localparam int unsigned NumPeri  = 4;
  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned PageLsb  = 16;
  localparam int unsigned TagWidth = AddrWidth - PageLsb;
  // Counter only needs to reach TimeoutCycles-1.
  localparam int unsigned CntWidth = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(TimeoutCycles - 1);

  // 64 KiB page tags of the peripheral register windows (addr[63:16]).
  localparam logic [TagWidth-1:0] GpioTag = TagWidth'(32'h0000_4400);
  localparam logic [TagWidth-1:0] EthTag  = TagWidth'(32'h0000_4300);
  localparam logic [TagWidth-1:0] SpiTag  = TagWidth'(32'h0000_4200);
  localparam logic [TagWidth-1:0] UartTag = TagWidth'(32'h0000_4100);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic                 rr_q, rr_d;
  logic                 owner_q, owner_d;
  logic [1:0]           sel_q, sel_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [BeWidth-1:0]   be_q, be_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic                 any_req;
  logic                 winner;
  logic [NumReq-1:0]    gnt;
  logic [2:0]           dec;  // {hit, peripheral index}
  logic                 timeout;

  // Returns {hit, index}; index is 0 GPIO, 1 Ethernet, 2 SPI, 3 UART.
  function automatic logic [2:0] decode_page(input logic [AddrWidth-1:0] addr);
    logic [TagWidth-1:0] tag;
    tag = addr[AddrWidth-1:PageLsb];
    if (tag == GpioTag) begin
      decode_page = {1'b1, 2'd0};
    end else if (tag == EthTag) begin
      decode_page = {1'b1, 2'd1};
    end else if (tag == SpiTag) begin
      decode_page = {1'b1, 2'd2};
    end else if (tag == UartTag) begin
      decode_page = {1'b1, 2'd3};
    end else begin
      decode_page = 3'b000;
    end
  endfunction

  // Round-robin: rr names the preferred requester when both request.
  always_comb begin
    any_req = |bus.req_i;
    if (bus.req_i[0] && bus.req_i[1]) begin
      winner = rr_q;
    end else begin
      winner = bus.req_i[1];
    end
    dec = decode_page(bus.addr_i[winner]);
  end

  assign timeout = (cnt_q == CntMax);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    gnt     = '0;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          gnt[winner] = 1'b1;
          rr_d        = ~winner;
          owner_d     = winner;
          addr_d      = bus.addr_i[winner];
          we_d        = bus.we_i[winner];
          wdata_d     = bus.wdata_i[winner];
          be_d        = bus.be_i[winner];
          sel_d       = dec[1:0];
          cnt_d       = '0;
          if (dec[2]) begin
            state_d = StIssue;
          end else begin
            // Decode miss is answered directly without touching a peripheral.
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end

      StIssue: begin
        // A grant landing on the last counted cycle is not a completion, so the
        // abort still takes it.
        if (timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
          if (bus.p_gnt_i[sel_q]) begin
            state_d = StWait;
          end
        end
      end

      StWait: begin
        // Completion wins over timeout in the same cycle.
        if (bus.p_rvalid_i[sel_q]) begin
          rdata_d = bus.p_rdata_i[sel_q];
          err_d   = bus.p_err_i[sel_q];
          state_d = StResp;
        end else if (timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      sel_q   <= 2'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    bus.gnt_o     = gnt;
    bus.rvalid_o  = '0;
    bus.p_req_o   = '0;
    if (state_q == StResp) begin
      bus.rvalid_o[owner_q] = 1'b1;
    end
    if (state_q == StIssue) begin
      bus.p_req_o[sel_q] = 1'b1;
    end
    // rdata/err hold their last value outside RESP.
    bus.rdata_o   = rdata_q;
    bus.err_o     = err_q;
    bus.p_addr_o  = addr_q;
    bus.p_we_o    = we_q;
    bus.p_wdata_o = wdata_q;
    bus.p_be_o    = be_q;
  end

endmodule
